aes_inv_round_ctrl: RTL and testbench
=====================================

Name: aes_inv_round_ctrl

Overview:
Iterative AES decryption sequencer that owns the 128-bit state register and drives the combinational inverse-round datapath once per clock. That datapath is invShiftRows -> invSubBytes -> AddRoundKey -> invMixColumns, with invMixColumns bypassed on the last round. The block fetches round keys by index from the key-schedule store and accepts and returns blocks on valid/ready handshakes. It sits between the ciphertext input stream and the plaintext output stream of the decryption core.

Parameters:
NR, 10, number of AES rounds (10/12/14 for AES-128/192/256); sets key_idx start value
IDXW, 4, width of key_idx and round counter; must satisfy 2^IDXW > NR

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  abort current block, return to IDLE
in_valid  input  1  ciphertext block available
in_ready  output  1  controller can accept a block
in_data  input  128  ciphertext, state byte 0 (row0,col0) in bits [7:0], column-major
key_idx  output  IDXW  round-key index requested this cycle
key_in  input  128  round key for key_idx, combinationally valid same cycle
dp_state  output  128  current state register to inverse-round datapath
dp_last  output  1  datapath must bypass invMixColumns this cycle
dp_result  input  128  combinational inverse-round result
out_valid  output  1  plaintext block available
out_ready  input  1  consumer accepts block
out_data  output  128  plaintext (state register)
busy  output  1  high in ROUND or DONE

Behaviour:
- States: IDLE, ROUND, DONE. One-hot or binary is implementer's choice.
- Reset (rst=1 at an edge): state reg=0, round cnt=0, FSM=IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, key_idx=NR, dp_last=0, out_data=0.
- IDLE:
  - key_idx=NR, in_ready=1.
  - On in_valid&in_ready: state <= in_data ^ key_in (initial AddRoundKey), cnt <= NR-1, go ROUND.
- ROUND:
  - key_idx=cnt, dp_state=state, dp_last=(cnt==0), in_ready=0.
  - Each cycle: state <= dp_result.
  - cnt!=0: cnt <= cnt-1.
  - cnt==0: go DONE.
- DONE:
  - out_valid=1, out_data=state.
  - On out_ready: go IDLE.
  - out_data stable while out_valid&!out_ready.
  - No new input is accepted until the handshake completes; in_ready=0 in DONE.
- Latency: input accepted at edge t -> out_valid high from cycle t+NR+1. Exactly NR ROUND cycles, one key fetch each, indices NR-1 down to 0.
- Throughput: one block per NR+2 cycles when out_ready is held high (IDLE accept cycle + NR rounds + DONE cycle).
- dp_state always equals the state register. dp_last=0 outside ROUND.
- flush:
  - Any state -> IDLE next edge; out_valid drops, state reg unchanged.
  - In IDLE, flush has priority over an in_valid accept: nothing is captured.
- rst has priority over flush and all handshakes. Reset mid-ROUND or mid-DONE discards the block with no output.
- key_idx never exceeds NR and never wraps below 0. The counter does not decrement past 0.
- in_valid while not ready: ignored, not latched. Upstream must hold data.

Test Plan:
- FIPS-197 AES-128: in_data=69c4e0d86a7b0430d8cdb78070b4c55a (byte0 in [7:0]), round keys from 000102030405060708090a0b0c0d0e0f, out_ready=1 -> out_valid at accept+11, out_data=00112233445566778899aabbccddeeff. key_idx sequence 10,9,...,0; dp_last high only on the key_idx=0 cycle.
- Back-to-back: two blocks with in_valid held high and out_ready=1 -> second accepted exactly 12 cycles after the first, both plaintexts correct, in_ready low throughout ROUND/DONE.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_data held constant, in_ready=0. Releasing out_ready -> IDLE next cycle, in_ready=1.
- flush asserted at third ROUND cycle -> next cycle IDLE, out_valid never asserts. A following block then decrypts correctly.
- rst asserted mid-ROUND and in DONE -> next cycle all outputs at reset values (in_ready=1, out_valid=0, key_idx=10, busy=0).
- NR=14 build with AES-256 vector 8ea2b7ca516745bfeafc49904b496089 and key 000102..1f -> out_data=00112233445566778899aabbccddeeff after 15 cycles.

Source files
------------

// File: rtl/aes_inv_round_ctrl_if.sv
// Block and datapath bundle for the iterative AES decryption sequencer:
// ciphertext in, plaintext out, round-key fetch and inverse-round datapath.
interface aes_inv_round_ctrl_if #(
  parameter int IDXW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [127:0]    in_data;
  logic [IDXW-1:0] key_idx;
  logic [127:0]    key_in;
  logic [127:0]    dp_state;
  logic            dp_last;
  logic [127:0]    dp_result;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    out_data;

  modport master (
    input  in_valid, in_data, key_in, dp_result, out_ready,
    output in_ready, key_idx, dp_state, dp_last, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, key_in, dp_result, out_ready,
    input  in_ready, key_idx, dp_state, dp_last, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES decryption sequencer: owns the 128-bit state register and steps
// the external inverse-round datapath once per clock, NR rounds per block.
module aes_inv_round_ctrl #(
  parameter int NR   = 10,
  parameter int IDXW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  aes_inv_round_ctrl_if.master bus,
  output logic                 busy
);

  localparam logic [IDXW-1:0] IDX_NR    = IDXW'(NR);
  localparam logic [IDXW-1:0] IDX_FIRST = IDXW'(NR - 1);
  localparam logic [IDXW-1:0] IDX_ONE   = IDXW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          fsm_q;
  logic [127:0]    state_q;
  logic [127:0]    state_d;
  logic [IDXW-1:0] cnt_q;
  logic [IDXW-1:0] key_idx_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;
  logic            dp_last_q;
  logic            accept;

  assign accept = (fsm_q == IDLE) && in_ready_q && bus.in_valid;

  // Accept performs the initial AddRoundKey with key NR; each round takes the datapath result.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = bus.in_data ^ bus.key_in;
    end else if (fsm_q == ROUND) begin
      state_d = bus.dp_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      cnt_q       <= '0;
      key_idx_q   <= IDX_NR;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dp_last_q   <= 1'b0;
    end else if (flush) begin
      // Abort leaves the state register and counter untouched; only control returns to idle.
      fsm_q       <= IDLE;
      key_idx_q   <= IDX_NR;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dp_last_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (fsm_q)
        IDLE: begin
          if (accept) begin
            fsm_q      <= ROUND;
            cnt_q      <= IDX_FIRST;
            key_idx_q  <= IDX_FIRST;
            dp_last_q  <= (NR == 1);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ROUND: begin
          if (cnt_q != '0) begin
            cnt_q     <= cnt_q - IDX_ONE;
            key_idx_q <= cnt_q - IDX_ONE;
            dp_last_q <= (cnt_q == IDX_ONE);
          end else begin
            fsm_q       <= DONE;
            key_idx_q   <= IDX_NR;
            dp_last_q   <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.key_idx   = key_idx_q;
  assign bus.dp_state  = state_q;
  assign bus.dp_last   = dp_last_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = state_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: supplies a behavioural AES key schedule and
// inverse-round datapath, and tracks expected outputs with a block-level model.
module tb_aes_inv_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic flush14;
  logic busy10;
  logic busy14;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   rnd = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_round_ctrl_if #(.IDXW(4)) bus10 ();
  aes_inv_round_ctrl_if #(.IDXW(4)) bus14 ();

  aes_inv_round_ctrl #(.NR(10), .IDXW(4)) u10 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus10.master), .busy(busy10)
  );
  aes_inv_round_ctrl #(.NR(14), .IDXW(4)) u14 (
    .clk(clk), .rst(rst), .flush(flush14), .bus(bus14.master), .busy(busy14)
  );

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p, e;
    r = 8'h01; p = a; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[0]) r = gmul(r, p);
      p = gmul(p, p);
      e = {1'b0, e[7:1]};
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[127-8*i -: 8];
    return y;
  endfunction

  // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t, u;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[8*(4*c+r) +: 8] = inv_sbox(s[8*(4*((c - r + 4) % 4) + r) +: 8]);
    t = t ^ k;
    if (last) return t;
    for (int c = 0; c < 4; c++) begin
      a0 = t[8*(4*c)   +: 8]; a1 = t[8*(4*c+1) +: 8];
      a2 = t[8*(4*c+2) +: 8]; a3 = t[8*(4*c+3) +: 8];
      u[8*(4*c)   +: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
      u[8*(4*c+1) +: 8] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
      u[8*(4*c+2) +: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
      u[8*(4*c+3) +: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
    end
    return u;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Key bytes are taken from the top of 'key' downward (byte 0 first).
  function automatic logic [127:0] round_key(input logic [255:0] key, input int nk,
                                             input int nr, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++)
      for (int j = 0; j < 4; j++) w[i][8*j +: 8] = key[255-8*(4*i+j) -: 8];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[7:0], t[31:8]});
        t[7:0] = t[7:0] ^ rc;
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endfunction

  logic [127:0] rk10 [0:10];
  logic [127:0] rk14 [0:14];

  function automatic logic [127:0] aes_dec10(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk10[10];
    for (int r = 9; r >= 0; r--) s = inv_round(s, rk10[r], r == 0);
    return s;
  endfunction

  // Key-schedule store and combinational datapath seen by each controller.
  assign bus10.key_in    = rk10[bus10.key_idx];
  assign bus10.dp_result = inv_round(bus10.dp_state, bus10.key_in, bus10.dp_last);
  assign bus14.key_in    = rk14[bus14.key_idx];
  assign bus14.dp_result = inv_round(bus14.dp_state, bus14.key_in, bus14.dp_last);

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  logic [127:0] CT128, CT256, PT, RK10_LAST;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out, expected event never seen (cycle %0d)", nm, cyc);
  endtask

  // ---------------- block-level reference model for u10 ----------------
  bit           mv = 0;
  bit           m_blk = 0;
  int           m_age = 0;
  logic [127:0] m_st = '0;
  logic [127:0] m_pt = '0;

  always @(negedge clk) begin
    if (mv) begin
      chk("dp_state", bus10.dp_state, m_st);
      if (!m_blk) begin
        chk("idle_in_ready", 128'(bus10.in_ready), 128'd1);
        chk("idle_out_valid", 128'(bus10.out_valid), 128'd0);
        chk("idle_busy", 128'(busy10), 128'd0);
        chk("idle_key_idx", 128'(bus10.key_idx), 128'd10);
        chk("idle_dp_last", 128'(bus10.dp_last), 128'd0);
      end else if (m_age <= 10) begin
        chk("round_in_ready", 128'(bus10.in_ready), 128'd0);
        chk("round_out_valid", 128'(bus10.out_valid), 128'd0);
        chk("round_busy", 128'(busy10), 128'd1);
        chk("round_key_idx", 128'(bus10.key_idx), 128'(10 - m_age));
        chk("round_dp_last", 128'(bus10.dp_last), 128'(m_age == 10));
      end else begin
        chk("done_in_ready", 128'(bus10.in_ready), 128'd0);
        chk("done_out_valid", 128'(bus10.out_valid), 128'd1);
        chk("done_busy", 128'(busy10), 128'd1);
        chk("done_dp_last", 128'(bus10.dp_last), 128'd0);
        chk("done_out_data", bus10.out_data, m_pt);
      end
    end
    // What the next rising edge must do with the inputs now presented.
    if (rst) begin
      mv = 1; m_blk = 0; m_st = '0;
    end else if (mv) begin
      if (flush) begin
        m_blk = 0;
      end else if (!m_blk) begin
        if (bus10.in_valid) begin
          m_blk = 1; m_age = 1;
          m_st = bus10.in_data ^ rk10[10];
          m_pt = aes_dec10(bus10.in_data);
        end
      end else if (m_age <= 10) begin
        m_st = inv_round(m_st, rk10[10 - m_age], m_age == 10);
        m_age++;
      end else if (bus10.out_ready) begin
        m_blk = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) begin
      bus10.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
    end
  endtask

  task automatic put(input logic [127:0] ct, output int acc);
    bus10.in_valid = 1'b1;
    bus10.in_data  = ct;
    acc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus10.in_ready === 1'b1 && !flush && !rst) acc = cyc;
      step();
      if (acc >= 0) break;
    end
    bus10.in_valid = 1'b0;
    if (acc < 0) tmo("accept");
  endtask

  task automatic wait_ov(output int c);
    c = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus10.out_valid === 1'b1) begin
        c = cyc;
        return;
      end
      step();
    end
    tmo("out_valid");
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_in_ready"}, 128'(bus10.in_ready), 128'd1);
    chk({nm, "_out_valid"}, 128'(bus10.out_valid), 128'd0);
    chk({nm, "_key_idx"}, 128'(bus10.key_idx), 128'd10);
    chk({nm, "_busy"}, 128'(busy10), 128'd0);
    chk({nm, "_dp_last"}, 128'(bus10.dp_last), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, c;
    logic [127:0] a, b, hold;
    rst = 1'b1; flush = 1'b0; flush14 = 1'b0;
    bus10.in_valid = 1'b0; bus10.in_data = '0; bus10.out_ready = 1'b1;
    bus14.in_valid = 1'b0; bus14.in_data = '0; bus14.out_ready = 1'b1;
    CT128 = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    CT256 = bswap(128'h8ea2b7ca516745bfeafc49904b496089);
    PT    = bswap(128'h00112233445566778899aabbccddeeff);
    RK10_LAST = bswap(128'h13111d7fe3944a17f307a78b4d2b30c5);
    for (int r = 0; r <= 10; r++) rk10[r] = round_key(K128, 4, 10, r);
    for (int r = 0; r <= 14; r++) rk14[r] = round_key(K256, 8, 14, r);

    // Literal anchors for the model itself.
    chk("model_sbox00", 128'(sbox(8'h00)), 128'h63);
    chk("model_sbox53", 128'(sbox(8'h53)), 128'hed);
    chk("model_isbox63", 128'(inv_sbox(8'h63)), 128'h00);
    chk("model_rk10", rk10[10], RK10_LAST);
    chk("model_dec_fips", aes_dec10(CT128), PT);

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    reset_vals("reset");
    chk("reset_out_data", bus10.out_data, 128'h0);
    step();

    // FIPS-197 AES-128 vector: key index walk, last-round flag and latency.
    put(CT128, acc);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("fips_key_idx", 128'(bus10.key_idx), 128'(10 - i));
      chk("fips_dp_last", 128'(bus10.dp_last), 128'(i == 10));
      step();
    end
    wait_ov(c);
    chk("fips_latency", 128'(c - acc), 128'd11);
    chk("fips_plain", bus10.out_data, PT);
    step();

    // Back-to-back with in_valid held high.
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    put(a, acc);
    put(b, acc2);
    chk("b2b_spacing", 128'(acc2 - acc), 128'd12);
    wait_ov(c);
    chk("b2b_plain2", bus10.out_data, aes_dec10(b));
    step();

    // Backpressure hold.
    bus10.out_ready = 1'b0;
    put(CT128, acc);
    wait_ov(c);
    hold = bus10.out_data;
    chk("bp_plain", hold, PT);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("bp_out_valid", 128'(bus10.out_valid), 128'd1);
      chk("bp_out_data", bus10.out_data, hold);
      chk("bp_in_ready", 128'(bus10.in_ready), 128'd0);
    end
    step();
    bus10.out_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("bp_release_in_ready", 128'(bus10.in_ready), 128'd1);
    chk("bp_release_out_valid", 128'(bus10.out_valid), 128'd0);
    step();

    // Flush on the third round cycle, then a clean block.
    put(CT128, acc);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 128'(bus10.in_ready), 128'd1);
    chk("flush_busy", 128'(busy10), 128'd0);
    for (int i = 0; i < 15; i++) begin
      step();
      @(negedge clk);
      chk("flush_no_out", 128'(bus10.out_valid), 128'd0);
    end
    step();
    put(CT128, acc);
    wait_ov(c);
    chk("post_flush_plain", bus10.out_data, PT);
    step();

    // Reset mid-round and in the done state.
    put(CT128, acc);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    reset_vals("rst_round");
    step();
    bus10.out_ready = 1'b0;
    put(CT128, acc);
    wait_ov(c);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    reset_vals("rst_done");
    step();
    bus10.out_ready = 1'b1;

    // AES-256 build (NR=14).
    @(negedge clk);
    chk("nr14_idle_key_idx", 128'(bus14.key_idx), 128'd14);
    step();
    bus14.in_valid = 1'b1;
    bus14.in_data  = CT256;
    acc = -1;
    for (int n = 0; n < 20 && acc < 0; n++) begin
      @(negedge clk);
      if (bus14.in_ready === 1'b1) acc = cyc;
      step();
    end
    bus14.in_valid = 1'b0;
    c = -1;
    for (int n = 0; n < 40 && c < 0; n++) begin
      @(negedge clk);
      if (bus14.out_valid === 1'b1) c = cyc;
      else step();
    end
    if (acc < 0 || c < 0) tmo("nr14_block");
    chk("nr14_latency", 128'(c - acc), 128'd15);
    chk("nr14_plain", bus14.out_data, PT);
    step();

    // Randomized traffic under a random key with random backpressure and flushes.
    for (int r = 0; r <= 10; r++)
      rk10[r] = round_key({$urandom, $urandom, $urandom, $urandom, 128'h0}, 4, 10, r);
    rnd = 1;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) step();
      put({$urandom, $urandom, $urandom, $urandom}, acc);
    end
    rnd = 0;
    flush = 1'b0;
    bus10.out_ready = 1'b1;
    repeat (30) step();

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
